wb_rr_arbiter: RTL and testbench

- Parametrised N-master to 1-slave Wishbone arbiter.
- Lets several DMA/SPI engines share the single PCI bridge master port, where today one engine is wired straight to the bridge.
- Round-robin fairness, registered grant, whole-cycle ownership (CYC-based, so CAB bursts are never split).
- Optional per-transfer watchdog that terminates hung slave cycles with ERR.

---
 rtl/wb_rr_arbiter_if.sv | 47 ++++
 rtl/wb_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bus bundle for the N-master round-robin arbiter: master-side slices plus the shared slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_rr_arbiter_if #(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int SW = DW / 8;

    logic [NUM_M-1:0]    m_cyc_i;
    logic [NUM_M-1:0]    m_stb_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [NUM_M-1:0]    m_cab_i;
    logic [NUM_M*SW-1:0] m_sel_i;
    logic [NUM_M*AW-1:0] m_adr_i;
    logic [NUM_M*DW-1:0] m_dat_i;
    logic [DW-1:0]       m_dat_o;
    logic [NUM_M-1:0]    m_ack_o;
    logic [NUM_M-1:0]    m_err_o;
    logic [NUM_M-1:0]    m_rty_o;

    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic                s_cab_o;
    logic [SW-1:0]       s_sel_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW-1:0]       s_dat_i;
    logic                s_ack_i;
    logic                s_err_i;
    logic                s_rty_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_sel_i, m_adr_i, m_dat_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_sel_o, s_adr_o, s_dat_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_sel_i, m_adr_i, m_dat_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_sel_o, s_adr_o, s_dat_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone round-robin arbiter with registered grant and whole-CYC ownership.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that ends hung slave transfers with ERR.
module wb_rr_arbiter #(
    parameter int NUM_M       = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    wb_rr_arbiter_if.slave   bus,
    output logic [NUM_M-1:0] grant_o,
    output logic             tmo_o
);
    localparam int SW = DW / 8;
    localparam int LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic {IDLE, OWN} state_e;

    state_e           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [LW-1:0]    last_q, last_d;
    logic [LW-1:0]    pick;
    logic             hit;
    logic             own;
    logic             stb_raw;
    logic             tmo_fire;

    assign own     = (state_q == OWN);
    assign stb_raw = own & bus.m_stb_i[last_q];

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Scan downward in distance so the requester nearest after last_q wins last.
    always_comb begin
        pick = last_q;
        hit  = 1'b0;
        for (int i = NUM_M; i >= 1; i--) begin
            if (bus.m_cyc_i[LW'((int'(last_q) + i) % NUM_M)]) begin
                pick = LW'((int'(last_q) + i) % NUM_M);
                hit  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d       = OWN;
                    last_d        = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                end
            end
            OWN: begin
                if (!bus.m_cyc_i[last_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q doubles as the mux select, so IDLE keeps presenting the previous owner's fields.
    assign bus.s_cyc_o = own & bus.m_cyc_i[last_q];
    assign bus.s_stb_o = stb_raw & ~tmo_fire;
    assign bus.s_we_o  = bus.m_we_i[last_q];
    assign bus.s_cab_o = bus.m_cab_i[last_q];
    assign bus.s_sel_o = bus.m_sel_i[int'(last_q)*SW +: SW];
    assign bus.s_adr_o = bus.m_adr_i[int'(last_q)*AW +: AW];
    assign bus.s_dat_o = bus.m_dat_i[int'(last_q)*DW +: DW];
    assign bus.m_dat_o = bus.s_dat_i;

    always_comb begin
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_rty_o = '0;
        if (own) begin
            bus.m_ack_o[last_q] = bus.s_ack_i & ~tmo_fire;
            bus.m_err_o[last_q] = bus.s_err_i | tmo_fire;
            bus.m_rty_o[last_q] = bus.s_rty_i & ~tmo_fire;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          resp;

    assign resp = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    // Fires on the TIMEOUT_CYC-th consecutive strobed cycle, regardless of a late response.
    assign tmo_fire = stb_raw && (tcnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        tcnt_d = '0;
        if (state_d == OWN && stb_raw && !resp && !tmo_fire)
            tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) tcnt_q <= '0;
        else            tcnt_q <= tcnt_d;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    assign grant_o = grant_q;
    assign tmo_o   = tmo_fire;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized bench for wb_rr_arbiter (3 masters) against a cycle-level ownership model,
// plus directed handover, error routing, stalled-slave and async-reset scenarios.
module tb_wb_rr_arbiter;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 16;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] grant;
    logic         tmo;

    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NUM_M(N), .AW(AW), .DW(DW)) bus();

    wb_rr_arbiter #(.NUM_M(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(T)) dut (
        .wb_clk_i (clk),
        .wb_rstn_i(rstn),
        .bus      (bus),
        .grant_o  (grant),
        .tmo_o    (tmo)
    );

    int           checks = 0;
    int           errors = 0;
    int           owner;
    int           last;
    int           cnt;
    int           beats [N];
    logic [N-1:0] resp_seen;
    bit           hang;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = N - 1;
        cnt   = 0;
        for (int k = 0; k < N; k++) beats[k] = 0;
        resp_seen = '0;
    endtask

    function automatic bit fire_now();
        bit f;
        f = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        f = (owner >= 0) && bus.m_stb_i[owner] && (cnt == T - 1);
`endif
        return f;
    endfunction

    task automatic check_outs();
        int           g;
        bit           f;
        logic [N-1:0] eg, ea, ee, er;
        g  = (owner >= 0) ? owner : last;
        f  = fire_now();
        eg = '0; ea = '0; ee = '0; er = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ea[owner] = bus.s_ack_i & !f;
            ee[owner] = bus.s_err_i | f;
            er[owner] = bus.s_rty_i & !f;
        end
        chk("grant", grant, eg);
        chk("s_cyc", bus.s_cyc_o, (owner >= 0) && bus.m_cyc_i[owner]);
        chk("s_stb", bus.s_stb_o, (owner >= 0) && bus.m_stb_i[owner] && !f);
        chk("s_we",  bus.s_we_o,  bus.m_we_i[g]);
        chk("s_cab", bus.s_cab_o, bus.m_cab_i[g]);
        chk("s_sel", bus.s_sel_o, bus.m_sel_i[g*SW +: SW]);
        chk("s_adr", bus.s_adr_o, bus.m_adr_i[g*AW +: AW]);
        chk("s_dat", bus.s_dat_o, bus.m_dat_i[g*DW +: DW]);
        chk("m_dat", bus.m_dat_o, bus.s_dat_i);
        chk("m_ack", bus.m_ack_o, ea);
        chk("m_err", bus.m_err_o, ee);
        chk("m_rty", bus.m_rty_o, er);
        chk("tmo",   tmo, f);
        resp_seen = ea | ee | er;
    endtask

    // Ownership rules applied at the clock edge to the inputs present before it.
    task automatic model_edge();
        bit f, stalled;
        if (owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                if (owner < 0 && bus.m_cyc_i[(last + i) % N]) begin
                    owner = (last + i) % N;
                    last  = owner;
                end
            end
            cnt = 0;
        end else begin
            f       = fire_now();
            stalled = bus.m_stb_i[owner] && !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i);
            cnt     = (f || !stalled) ? 0 : cnt + 1;
            if (!bus.m_cyc_i[owner]) begin
                owner = -1;
                cnt   = 0;
            end
        end
    endtask

    task automatic cycle();
        #1 check_outs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive_masters();
        for (int k = 0; k < N; k++) begin
            if (beats[k] > 0 && resp_seen[k]) beats[k]--;
            if (beats[k] > 0 && $urandom_range(0, 40) == 0) beats[k] = 0;
            else if (beats[k] == 0 && !bus.m_cyc_i[k] && $urandom_range(0, 3) == 0)
                beats[k] = $urandom_range(1, 8);
            bus.m_cyc_i[k] = (beats[k] > 0);
            bus.m_stb_i[k] = (beats[k] > 0) && ($urandom_range(0, 3) != 0);
            bus.m_we_i[k]  = $urandom_range(0, 1) != 0;
            bus.m_cab_i[k] = (beats[k] > 1);
            bus.m_sel_i[k*SW +: SW] = SW'($urandom);
            bus.m_adr_i[k*AW +: AW] = AW'($urandom);
            bus.m_dat_i[k*DW +: DW] = $urandom;
        end
    endtask

    task automatic drive_slave();
        bus.s_ack_i = !hang && ($urandom_range(0, 2) == 0);
        bus.s_err_i = !hang && ($urandom_range(0, 15) == 0);
        bus.s_rty_i = !hang && ($urandom_range(0, 15) == 0);
        bus.s_dat_i = $urandom;
    endtask

    task automatic set_masters(input logic [N-1:0] cyc, input logic [N-1:0] stb);
        bus.m_cyc_i = cyc;
        bus.m_stb_i = stb;
        bus.m_cab_i = '0;
    endtask

    initial begin
        int ntmo, first_tmo, exp_ntmo, exp_first;
        hang = 1'b0;
        set_masters('0, '0);
        bus.m_we_i  = '0;
        bus.m_sel_i = '1;
        bus.m_adr_i = {16'h3000, 16'h2000, 16'h1000};
        bus.m_dat_i = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        bus.s_dat_i = 32'h5A5A_A5A5;
        bus.s_ack_i = 1'b1;
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b0;
        model_reset();

        #3;
        chk("rst_grant", grant, 3'b000);
        chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
        chk("rst_s_stb", bus.s_stb_o, 1'b0);
        chk("rst_m_ack", bus.m_ack_o, 3'b000);
        chk("rst_tmo",   tmo, 1'b0);

        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        bus.s_ack_i = 1'b0;

        // Two simultaneous requesters: master 0 first, master 1 after an idle cycle.
        set_masters(3'b011, 3'b011);
        cycle();
        chk("t1_grant0", grant, 3'b001);
        chk("t1_adr0", bus.s_adr_o, 16'h1000);
        bus.s_ack_i = 1'b1;
        #1 chk("t1_ack0", bus.m_ack_o, 3'b001);
        cycle();
        bus.s_ack_i = 1'b0;
        set_masters(3'b010, 3'b010);
        #1 chk("t1_rel_cyc", bus.s_cyc_o, 1'b0);
        cycle();
        chk("t1_idle", grant, 3'b000);
        cycle();
        chk("t1_grant1", grant, 3'b010);
        chk("t1_adr1", bus.s_adr_o, 16'h2000);

        bus.s_err_i = 1'b1;
        #1 chk("err_route", bus.m_err_o, 3'b010);
        cycle();
        bus.s_err_i = 1'b0;

        // Slave never answers master 1.
        ntmo = 0;
        first_tmo = -1;
        for (int i = 0; i < 20; i++) begin
            #1 if (tmo) begin
                ntmo++;
                if (first_tmo < 0) first_tmo = i;
            end
            cycle();
        end
`ifdef WB_ARB_TIMEOUT_EN
        exp_ntmo = 1; exp_first = T - 1;
`else
        exp_ntmo = 0; exp_first = -1;
`endif
        chk("hang_tmo_cnt", ntmo, exp_ntmo);
        chk("hang_tmo_at", first_tmo, exp_first);
        chk("hang_stb", bus.s_stb_o, 1'b1);

        set_masters(3'b000, 3'b000);
        cycle();
        bus.s_ack_i = 1'b1;
        #1 chk("idle_ack", bus.m_ack_o, 3'b000);
        cycle();
        bus.s_ack_i = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            drive_masters();
            drive_slave();
            cycle();
        end

        // Reset while master 2 owns the bus with a live ACK.
        for (int k = 0; k < N; k++) beats[k] = 0;
        set_masters(3'b000, 3'b000);
        bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
        cycle();
        cycle();
        set_masters(3'b100, 3'b100);
        bus.m_cab_i = 3'b100;
        bus.s_ack_i = 1'b1;
        cycle();
        cycle();
        chk("pre_rst_cyc", bus.s_cyc_o, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_s_cyc", bus.s_cyc_o, 1'b0);
        chk("arst_s_stb", bus.s_stb_o, 1'b0);
        chk("arst_grant", grant, 3'b000);
        chk("arst_m_ack", bus.m_ack_o, 3'b000);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        bus.s_ack_i = 1'b0;
        set_masters(3'b111, 3'b111);
        cycle();
        chk("rst_first", grant, 3'b001);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
